// File: rtl/tc_program_loader_if.sv
// Byte-stream input and program-memory write port of tc_program_loader.
// master = host/debug byte source side, slave = the loader.
interface tc_program_loader_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  start;
  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [7:0]            wr_data;
  logic                  cpu_hold;
  logic                  done;
  logic                  error;
  logic [8:0]            byte_count;

  modport master (
    output start, in_data, in_valid,
    input  in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error, byte_count
  );

  modport slave (
    input  start, in_data, in_valid,
    output in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error, byte_count
  );
endinterface

// File: rtl/tc_program_loader.sv
// Loads a length-framed byte stream into program RAM and holds the CPU meanwhile.
// Define TC_PROGRAM_LOADER_CHECKSUM_EN to require a trailing checksum byte.
module tc_program_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  tc_program_loader_if.slave   ldr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
`ifdef TC_PROGRAM_LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [9:0] DEPTH_W = 10'(DEPTH);

  state_t                state_q, state_d;
  logic [8:0]            n_q, n_d;
  logic [8:0]            count_q, count_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]            wr_data_q, wr_data_d;
`ifdef TC_PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]            sum_q, sum_d;
  logic [7:0]            sum_plus;
`endif

  logic       in_ready;
  logic       accept;
  logic       restart;
  logic [8:0] len_n;
  logic       last_byte;

  // A length byte of zero encodes a full 256-byte payload.
  assign len_n     = (ldr.in_data == 8'd0) ? 9'd256 : {1'b0, ldr.in_data};
  assign accept    = ldr.in_valid && in_ready;
  assign restart   = ldr.start &&
                     (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);
  assign last_byte = ((count_q + 9'd1) == n_q);
`ifdef TC_PROGRAM_LOADER_CHECKSUM_EN
  assign sum_plus  = sum_q + ldr.in_data;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      n_q       <= '0;
      count_q   <= '0;
      addr_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
`ifdef TC_PROGRAM_LOADER_CHECKSUM_EN
      sum_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      count_q   <= count_d;
      addr_q    <= addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
`ifdef TC_PROGRAM_LOADER_CHECKSUM_EN
      sum_q     <= sum_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: if (ldr.start) state_d = S_LEN;
      S_LEN: if (accept) state_d = ({1'b0, len_n} > DEPTH_W) ? S_ERR : S_DATA;
      S_DATA: begin
        if (accept && last_byte) begin
`ifdef TC_PROGRAM_LOADER_CHECKSUM_EN
          state_d = S_CSUM;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef TC_PROGRAM_LOADER_CHECKSUM_EN
      S_CSUM: if (accept) state_d = (sum_plus == 8'd0) ? S_DONE : S_ERR;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: the write is registered so it lands the cycle after the accept,
  // together with the state change into DONE/CSUM.
  always_comb begin
    n_d       = n_q;
    count_d   = count_q;
    addr_d    = addr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
`ifdef TC_PROGRAM_LOADER_CHECKSUM_EN
    sum_d     = sum_q;
`endif
    if (restart) begin
      count_d = '0;
      addr_d  = '0;
`ifdef TC_PROGRAM_LOADER_CHECKSUM_EN
      sum_d   = '0;
`endif
    end
    if (accept && state_q == S_LEN) begin
      n_d = len_n;
`ifdef TC_PROGRAM_LOADER_CHECKSUM_EN
      sum_d = sum_plus;
`endif
    end
    if (accept && state_q == S_DATA) begin
      wr_en_d   = 1'b1;
      wr_addr_d = addr_q;
      wr_data_d = ldr.in_data;
      addr_d    = addr_q + ADDR_WIDTH'(1);
      count_d   = count_q + 9'd1;
`ifdef TC_PROGRAM_LOADER_CHECKSUM_EN
      sum_d     = sum_plus;
`endif
    end
  end

  always_comb begin
    in_ready     = 1'b0;
    ldr.cpu_hold = 1'b0;
    ldr.done     = 1'b0;
    ldr.error    = 1'b0;
    case (state_q)
      S_LEN, S_DATA: begin
        in_ready     = 1'b1;
        ldr.cpu_hold = 1'b1;
      end
`ifdef TC_PROGRAM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        in_ready     = 1'b1;
        ldr.cpu_hold = 1'b1;
      end
`endif
      S_DONE: ldr.done = 1'b1;
      S_ERR: begin
        ldr.error    = 1'b1;
        ldr.cpu_hold = 1'b1;
      end
      default: ;
    endcase
  end

  assign ldr.in_ready   = in_ready;
  assign ldr.wr_en      = wr_en_q;
  assign ldr.wr_addr    = wr_addr_q;
  assign ldr.wr_data    = wr_data_q;
  assign ldr.byte_count = count_q;

endmodule

// File: tb/tb_tc_program_loader.sv
// Bench for tc_program_loader: table-driven and random frames against a frame-level model.
// Works with and without TC_PROGRAM_LOADER_CHECKSUM_EN defined.
module tb_tc_program_loader;

`ifdef TC_PROGRAM_LOADER_CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int         cyc;
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;
  typedef struct {
    logic [7:0] len;
    bit         bad;
    int         gap;
    logic       exp_done;
    logic       exp_error;
    int         exp_count;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tc_program_loader_if #(.ADDR_WIDTH(8)) bus ();
  tc_program_loader_if #(.ADDR_WIDTH(8)) bus16 ();

  tc_program_loader #(.ADDR_WIDTH(8), .DEPTH(256)) dut   (.clk(clk), .rst(rst), .ldr(bus.slave));
  tc_program_loader #(.ADDR_WIDTH(8), .DEPTH(16))  dut16 (.clk(clk), .rst(rst), .ldr(bus16.slave));

  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc      = 0;
  wr_t obs[$];
  wr_t obs16[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.wr_en)   obs.push_back('{cyc, bus.wr_addr, bus.wr_data});
    if (bus16.wr_en) obs16.push_back('{cyc, bus16.wr_addr, bus16.wr_data});
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic v, input logic [7:0] d);
    if (sel) begin bus16.in_valid = v; bus16.in_data = d; end
    else     begin bus.in_valid   = v; bus.in_data   = d; end
  endtask

  function automatic logic rdy(input bit sel);
    return sel ? bus16.in_ready : bus.in_ready;
  endfunction

  task automatic pulse_start(input bit sel);
    if (sel) bus16.start = 1'b1; else bus.start = 1'b1;
    @(negedge clk);
    bus16.start = 1'b0;
    bus.start   = 1'b0;
  endtask

  // Offer one byte (after an optional idle gap) and return once it was taken.
  task automatic send_byte(input bit sel, input logic [7:0] b, input int gap);
    int t = 0;
    if (gap > 0) begin
      drive(sel, 1'b0, 8'h00);
      repeat (gap) @(negedge clk);
    end
    drive(sel, 1'b1, b);
    while (!rdy(sel) && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!rdy(sel)) chk("send_timeout_in_ready", 32'(rdy(sel)), 32'd1);
    @(negedge clk);
  endtask

  function automatic logic [7:0] good_csum(input logic [7:0] len, input bq_t pay);
    int s = int'(len);
    foreach (pay[i]) s += int'(pay[i]);
    return 8'((256 - (s % 256)) % 256);
  endfunction

  task automatic run_frame(input logic [7:0] len, input bq_t pay, input logic [7:0] c, input int max_gap);
    obs.delete();
    pulse_start(1'b0);
    send_byte(1'b0, len, 0);
    foreach (pay[i]) send_byte(1'b0, pay[i], (max_gap > 0) ? $urandom_range(0, max_gap) : 0);
    if (CSUM_ON) send_byte(1'b0, c, 0);
    drive(1'b0, 1'b0, 8'h00);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_frame(input string name, input bq_t pay, input logic exp_done, input logic exp_err);
    int bad = 0;
    chk({name, "_nwrites"}, 32'(obs.size()), 32'(pay.size()));
    foreach (obs[i]) begin
      if (i < pay.size()) begin
        if (obs[i].addr !== 8'(i) || obs[i].data !== pay[i]) bad++;
      end
    end
    chk({name, "_write_mismatches"}, 32'(bad), 32'd0);
    chk({name, "_done"}, 32'(bus.done), 32'(exp_done));
    chk({name, "_error"}, 32'(bus.error), 32'(exp_err));
    chk({name, "_cpu_hold"}, 32'(bus.cpu_hold), 32'(exp_err));
    chk({name, "_byte_count"}, 32'(bus.byte_count), 32'(pay.size()));
    chk({name, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    $display("frame %s: N=%0d writes=%0d done=%0b error=%0b", name, pay.size(), obs.size(), bus.done, bus.error);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bq_t  pay;
    vec_t tbl[6];
    logic [7:0] c;
    int   sum;
    logic exp_done;
    int   nb;

    bus.start = 1'b0;   bus.in_valid = 1'b0;   bus.in_data = 8'h00;
    bus16.start = 1'b0; bus16.in_valid = 1'b0; bus16.in_data = 8'h00;
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
    chk("rst_outputs_or", 32'(bus.wr_addr | bus.wr_data | 8'(bus.byte_count)), 32'd0);
    chk("rst_flags", {29'd0, bus.cpu_hold, bus.done, bus.error}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_in_ready", 32'(bus.in_ready), 32'd0);

    // Basic three-byte frame, back-to-back writes
    pay = '{8'hA1, 8'hB2, 8'hC3};
    run_frame(8'h03, pay, 8'hE7, 0);
    check_frame("basic", pay, 1'b1, 1'b0);
    if (obs.size() == 3) begin
      chk("basic_consecutive_1", 32'(obs[1].cyc - obs[0].cyc), 32'd1);
      chk("basic_consecutive_2", 32'(obs[2].cyc - obs[1].cyc), 32'd1);
    end

    // Wrong checksum: payload still written, then ERR; start clears error
    if (CSUM_ON) begin
      run_frame(8'h03, pay, 8'h00, 0);
      check_frame("bad_csum", pay, 1'b0, 1'b1);
      pulse_start(1'b0);
      chk("restart_error_cleared", 32'(bus.error), 32'd0);
      chk("restart_in_ready", 32'(bus.in_ready), 32'd1);
      do_reset();
    end

    // Full 256-byte payload encoded as L = 0
    pay = {};
    for (int i = 0; i < 256; i++) pay.push_back(8'(i));
    run_frame(8'h00, pay, good_csum(8'h00, pay), 0);
    check_frame("full256", pay, 1'b1, 1'b0);
    if (obs.size() > 0) begin
      chk("full256_last_addr", 32'(obs[obs.size()-1].addr), 32'hFF);
      chk("full256_last_data", 32'(obs[obs.size()-1].data), 32'hFF);
    end

    // Handshake gaps with a start pulse in the middle of DATA
    pay = '{8'h11, 8'h22, 8'h33, 8'h44};
    obs.delete();
    pulse_start(1'b0);
    send_byte(1'b0, 8'h04, 0);
    send_byte(1'b0, 8'h11, 0);
    drive(1'b0, 1'b0, 8'h00);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    send_byte(1'b0, 8'h22, 0);
    send_byte(1'b0, 8'h33, 0);
    send_byte(1'b0, 8'h44, 0);
    if (CSUM_ON) send_byte(1'b0, good_csum(8'h04, pay), 0);
    drive(1'b0, 1'b0, 8'h00);
    repeat (2) @(negedge clk);
    check_frame("gaps", pay, 1'b1, 1'b0);
    if (obs.size() >= 2) chk("gaps_spacing", 32'(obs[1].cyc - obs[0].cyc), 32'd3);

    // Table of frames with random payloads
    tbl[0] = '{8'd1,   1'b0, 0, 1'b1,      1'b0,    1};
    tbl[1] = '{8'd2,   1'b1, 1, !CSUM_ON,  CSUM_ON, 2};
    tbl[2] = '{8'd7,   1'b1, 2, !CSUM_ON,  CSUM_ON, 7};
    tbl[3] = '{8'd16,  1'b0, 1, 1'b1,      1'b0,    16};
    tbl[4] = '{8'd255, 1'b0, 0, 1'b1,      1'b0,    255};
    tbl[5] = '{8'd1,   1'b1, 0, !CSUM_ON,  CSUM_ON, 1};
    foreach (tbl[k]) begin
      pay = {};
      for (int i = 0; i < int'(tbl[k].len); i++) pay.push_back(8'($urandom));
      c = good_csum(tbl[k].len, pay);
      if (tbl[k].bad) c = c ^ 8'h5A;
      run_frame(tbl[k].len, pay, c, tbl[k].gap);
      check_frame($sformatf("tbl%0d", k), pay, tbl[k].exp_done, tbl[k].exp_error);
      chk($sformatf("tbl%0d_count", k), 32'(bus.byte_count), 32'(tbl[k].exp_count));
    end

    // Random frames checked against the frame-level model
    for (int k = 0; k < 12; k++) begin
      nb = $urandom_range(1, 64);
      pay = {};
      for (int i = 0; i < nb; i++) pay.push_back(8'($urandom));
      c = 8'($urandom);
      if ($urandom_range(0, 2) != 0) c = good_csum(8'(nb), pay);
      sum = nb + int'(c);
      foreach (pay[i]) sum += int'(pay[i]);
      exp_done = CSUM_ON ? ((sum % 256) == 0) : 1'b1;
      run_frame(8'(nb), pay, c, 2);
      check_frame($sformatf("rnd%0d", k), pay, exp_done, !exp_done);
    end

    // Asynchronous reset after 2 of 5 payload bytes
    obs.delete();
    pulse_start(1'b0);
    send_byte(1'b0, 8'h05, 0);
    send_byte(1'b0, 8'h01, 0);
    send_byte(1'b0, 8'h02, 0);
    drive(1'b0, 1'b1, 8'h03);
    #2 rst = 1'b1;
    #1;
    chk("arst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("arst_wr_en", 32'(bus.wr_en), 32'd0);
    chk("arst_addr_data", {16'd0, bus.wr_addr, bus.wr_data}, 32'd0);
    chk("arst_flags", {29'd0, bus.cpu_hold, bus.done, bus.error}, 32'd0);
    chk("arst_byte_count", 32'(bus.byte_count), 32'd0);
    chk("arst_writes_before", 32'(obs.size()), 32'd2);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("arst_no_more_writes", 32'(obs.size()), 32'd2);
    chk("arst_idle_in_ready", 32'(bus.in_ready), 32'd0);
    chk("arst_idle_cpu_hold", 32'(bus.cpu_hold), 32'd0);
    drive(1'b0, 1'b0, 8'h00);
    $display("frame arst: writes=%0d in_ready=%0b", obs.size(), bus.in_ready);

    // DEPTH = 16: oversize length goes straight to ERR
    obs16.delete();
    pulse_start(1'b1);
    send_byte(1'b1, 8'h20, 0);
    drive(1'b1, 1'b1, 8'h55);
    chk("d16_error", 32'(bus16.error), 32'd1);
    chk("d16_in_ready", 32'(bus16.in_ready), 32'd0);
    chk("d16_cpu_hold", 32'(bus16.cpu_hold), 32'd1);
    repeat (3) @(negedge clk);
    chk("d16_no_writes", 32'(obs16.size()), 32'd0);
    drive(1'b1, 1'b0, 8'h00);
    $display("frame d16_oversize: writes=%0d error=%0b", obs16.size(), bus16.error);

    // DEPTH = 16: exactly 16 bytes is accepted
    pay = {};
    for (int i = 0; i < 16; i++) pay.push_back(8'($urandom));
    obs16.delete();
    pulse_start(1'b1);
    send_byte(1'b1, 8'h10, 0);
    foreach (pay[i]) send_byte(1'b1, pay[i], 0);
    if (CSUM_ON) send_byte(1'b1, good_csum(8'h10, pay), 0);
    drive(1'b1, 1'b0, 8'h00);
    repeat (2) @(negedge clk);
    chk("d16_full_nwrites", 32'(obs16.size()), 32'd16);
    chk("d16_full_done", 32'(bus16.done), 32'd1);
    chk("d16_full_error", 32'(bus16.error), 32'd0);
    chk("d16_full_count", 32'(bus16.byte_count), 32'd16);
    if (obs16.size() == 16) chk("d16_full_last", {16'd0, obs16[15].addr, obs16[15].data}, {16'd0, 8'h0F, pay[15]});
    $display("frame d16_full: writes=%0d done=%0b", obs16.size(), bus16.done);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule
